// File: rtl/lsu_mem_bridge_if.sv
// Bus bundle between the processor data port, the load/store bridge and
// the 32-bit synchronous data RAM. The slave modport is the bridge's view;
// the master modport is the view of the surrounding environment.
interface lsu_mem_bridge_if #(
  parameter int ADDR_W = 10
) ();
  logic              req;
  logic              we;
  logic [2:0]        size;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              err;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req, we, size, addr, wdata, mem_rdata,
    output rdata, done, err, busy, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req, we, size, addr, wdata, mem_rdata,
    input  rdata, done, err, busy, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: turns one byte/half/word processor access into one or
// two byte-lane-enabled word accesses on a 32-bit synchronous RAM, and
// sign/zero-extends load results.
//
// state | meaning
// IDLE  | waiting for req; captures the request
// ACC0  | first RAM word access in flight (word index w)
// ACC1  | second RAM word access for a misaligned request (w+1, wraps)
// RESP  | last read data arriving; result registered, done pulses next
//
// RAM-side outputs are registered from the next state so the RAM sees the
// access during ACC0/ACC1 itself. The result needs the read data that
// arrives during RESP, so done/rdata/err are registered on leaving RESP and
// busy is held through that done cycle.
module lsu_mem_bridge #(
  parameter int ADDR_W           = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic             clk,
  input logic             rst,
  lsu_mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state, state_nx;
  logic              cap_we, cap_err, cap_mis;
  logic [2:0]        cap_size;
  logic [1:0]        cap_off;
  logic [ADDR_W-1:0] cap_word;
  logic [31:0]       cap_wdata, word0;

  logic [7:0]        in_be8, cap_be8;
  logic [63:0]       in_wd64, cap_wd64;
  logic              in_mis, in_illegal, in_err;

  logic              en_nx, we_nx;
  logic [3:0]        be_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       wd_nx;

  logic [63:0]       rd64;
  logic [31:0]       rd_raw, rd_ext, resp_data;

  function automatic logic [3:0] size_mask(input logic [2:0] sz);
    logic [3:0] m;
    case (sz[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Lane enables and lane-aligned data spread over two words; the upper
  // word is only non-zero when the access crosses a word boundary.
  assign in_be8     = {4'b0000, size_mask(bus.size)} << bus.addr[1:0];
  assign in_wd64    = {32'h0, bus.wdata} << {bus.addr[1:0], 3'b000};
  assign in_mis     = |in_be8[7:4];
  assign in_illegal = (bus.size == 3'b011) || (bus.size[2:1] == 2'b11) ||
                      (bus.we && bus.size[2]);
  assign in_err     = in_illegal || (in_mis && !ALLOW_MISALIGNED);

  assign cap_be8    = {4'b0000, size_mask(cap_size)} << cap_off;
  assign cap_wd64   = {32'h0, cap_wdata} << {cap_off, 3'b000};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and the RAM access to present in that state.
  always_comb begin
    state_nx = state;
    en_nx    = 1'b0;
    we_nx    = 1'b0;
    be_nx    = 4'b0000;
    addr_nx  = '0;
    wd_nx    = 32'h0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (in_err) begin
            state_nx = RESP;
          end else begin
            state_nx = ACC0;
            en_nx    = 1'b1;
            we_nx    = bus.we;
            be_nx    = in_be8[3:0];
            addr_nx  = bus.addr[ADDR_W+1:2];
            wd_nx    = bus.we ? in_wd64[31:0] : 32'h0;
          end
        end
      end
      ACC0: begin
        if (cap_mis) begin
          state_nx = ACC1;
          en_nx    = 1'b1;
          we_nx    = cap_we;
          be_nx    = cap_be8[7:4];
          addr_nx  = cap_word + {{(ADDR_W-1){1'b0}}, 1'b1};
          wd_nx    = cap_we ? cap_wd64[63:32] : 32'h0;
        end else begin
          state_nx = RESP;
        end
      end
      ACC1:    state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Little-endian reassembly of the one or two read words, then extension.
  always_comb begin
    rd64   = cap_mis ? {bus.mem_rdata, word0} : {32'h0, bus.mem_rdata};
    rd_raw = 32'(rd64 >> {cap_off, 3'b000});
    rd_ext = rd_raw;
    case (cap_size)
      3'b000:  rd_ext = {{24{rd_raw[7]}}, rd_raw[7:0]};
      3'b001:  rd_ext = {{16{rd_raw[15]}}, rd_raw[15:0]};
      3'b100:  rd_ext = {24'h0, rd_raw[7:0]};
      3'b101:  rd_ext = {16'h0, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
    resp_data = (cap_err || cap_we) ? 32'h0 : rd_ext;
  end

  // Request capture in IDLE; first read word held while the second arrives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_mis   <= 1'b0;
      cap_size  <= 3'b000;
      cap_off   <= 2'b00;
      cap_word  <= '0;
      cap_wdata <= 32'h0;
      word0     <= 32'h0;
    end else if (state == IDLE && bus.req) begin
      cap_we    <= bus.we;
      cap_err   <= in_err;
      cap_mis   <= in_mis;
      cap_size  <= bus.size;
      cap_off   <= bus.addr[1:0];
      cap_word  <= bus.addr[ADDR_W+1:2];
      cap_wdata <= bus.wdata;
    end else if (state == ACC1) begin
      word0     <= bus.mem_rdata;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.rdata     <= 32'h0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
    end else begin
      bus.rdata     <= (state == RESP) ? resp_data : 32'h0;
      bus.done      <= (state == RESP);
      bus.err       <= (state == RESP) && cap_err;
      bus.busy      <= (state_nx != IDLE) || (state == RESP);
      bus.mem_en    <= en_nx;
      bus.mem_we    <= we_nx;
      bus.mem_be    <= be_nx;
      bus.mem_addr  <= addr_nx;
      bus.mem_wdata <= wd_nx;
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge with a behavioural 1024-word RAM and a
// log of every RAM access the bridge issues.
module tb_lsu_mem_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lsu_mem_bridge_if #(.ADDR_W(10)) bus ();

  lsu_mem_bridge #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram      [0:1023];
  logic [9:0]  log_addr [0:63];
  logic [3:0]  log_be   [0:63];
  logic [31:0] log_wd   [0:63];
  int          acc_total = 0;

  // RAM model: byte-lane writes, read data registered one cycle after mem_en.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
      log_addr[6'(acc_total)] <= bus.mem_addr;
      log_be[6'(acc_total)]   <= bus.mem_be;
      log_wd[6'(acc_total)]   <= bus.mem_wdata;
      acc_total <= acc_total + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          lat;
  int          a0;
  int          dn;
  logic [31:0] rd;
  logic        e;

  // One request pulse; lat counts rising edges from the accepting edge
  // (edge 1) to the first edge after which done is seen high.
  task automatic access(input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int l, output logic [31:0] r,
                        output logic ef, output int start);
    @(negedge clk);
    start     = acc_total;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
    l = 1;
    while (bus.done !== 1'b1 && l < 12) begin
      @(posedge clk); #1;
      l++;
    end
    r  = bus.rdata;
    ef = bus.err;
  endtask

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = 3'b000;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;

    repeat (3) @(posedge clk); #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_flags", {28'h0, bus.done, bus.err, bus.busy, bus.mem_en}, 32'h0);
    chk("rst_mem", {17'h0, bus.mem_we, bus.mem_be, bus.mem_addr}, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk); rst = 1'b1;

    // SW word 5
    access(1'b1, 3'b010, 32'h14, 32'h8844_2211, lat, rd, e, a0);
    chk("sw5_lat", lat, 32'd3);
    chk("sw5_rdata", rd, 32'h0);
    chk("sw5_nacc", acc_total - a0, 32'd1);
    chk("sw5_be", {28'h0, log_be[6'(a0)]}, 32'hF);
    chk("sw5_ram", ram[5], 32'h8844_2211);

    // Loads from word 5 with every extension flavour
    access(1'b0, 3'b000, 32'h16, 32'h0, lat, rd, e, a0);
    chk("lb16_lat", lat, 32'd3);
    chk("lb16_rdata", rd, 32'h0000_0044);
    @(posedge clk); #1;
    chk("done_pulse", {31'h0, bus.done}, 32'h0);
    access(1'b0, 3'b000, 32'h17, 32'h0, lat, rd, e, a0);
    chk("lb17_rdata", rd, 32'hFFFF_FF88);
    access(1'b0, 3'b100, 32'h17, 32'h0, lat, rd, e, a0);
    chk("lbu17_rdata", rd, 32'h0000_0088);
    access(1'b0, 3'b001, 32'h16, 32'h0, lat, rd, e, a0);
    chk("lh16_rdata", rd, 32'hFFFF_8844);
    access(1'b0, 3'b101, 32'h16, 32'h0, lat, rd, e, a0);
    chk("lhu16_rdata", rd, 32'h0000_8844);
    access(1'b0, 3'b010, 32'h14, 32'h0, lat, rd, e, a0);
    chk("lw14_rdata", rd, 32'h8844_2211);
    chk("lw14_err", {31'h0, e}, 32'h0);

    // SH into the upper half of word 8
    access(1'b1, 3'b010, 32'h20, 32'h1234_5678, lat, rd, e, a0);
    access(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, lat, rd, e, a0);
    chk("sh22_nacc", acc_total - a0, 32'd1);
    chk("sh22_addr", {22'h0, log_addr[6'(a0)]}, 32'd8);
    chk("sh22_be", {28'h0, log_be[6'(a0)]}, 32'hC);
    chk("sh22_wd_hi", {16'h0, log_wd[6'(a0)][31:16]}, 32'hBEEF);
    access(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, e, a0);
    chk("lw20_rdata", rd, 32'hBEEF_5678);

    // Misaligned LW across words 3/4
    access(1'b1, 3'b010, 32'h0C, 32'hDDCC_BBAA, lat, rd, e, a0);
    access(1'b1, 3'b010, 32'h10, 32'h4433_2211, lat, rd, e, a0);
    access(1'b0, 3'b010, 32'h0D, 32'h0, lat, rd, e, a0);
    chk("lw0d_lat", lat, 32'd4);
    chk("lw0d_nacc", acc_total - a0, 32'd2);
    chk("lw0d_acc0", {18'h0, log_be[6'(a0)], log_addr[6'(a0)]}, {18'h0, 4'b1110, 10'd3});
    chk("lw0d_acc1", {18'h0, log_be[6'(a0+1)], log_addr[6'(a0+1)]}, {18'h0, 4'b0001, 10'd4});
    chk("lw0d_rdata", rd, 32'h11DD_CCBB);

    // Misaligned LH across words 4/5
    access(1'b0, 3'b001, 32'h13, 32'h0, lat, rd, e, a0);
    chk("lh13_lat", lat, 32'd4);
    chk("lh13_rdata", rd, 32'h0000_1144);

    // SW at the top of the RAM wraps to word 0
    access(1'b1, 3'b010, 32'hFFF, 32'hA1B2_C3D4, lat, rd, e, a0);
    chk("swfff_lat", lat, 32'd4);
    chk("swfff_acc1_addr", {22'h0, log_addr[6'(a0+1)]}, 32'd0);
    chk("swfff_w1023", {24'h0, ram[1023][31:24]}, 32'hD4);
    chk("swfff_w0", {8'h0, ram[0][23:0]}, 32'h00A1_B2C3);
    access(1'b0, 3'b010, 32'hFFF, 32'h0, lat, rd, e, a0);
    chk("lwfff_rdata", rd, 32'hA1B2_C3D4);

    // Illegal requests
    access(1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, lat, rd, e, a0);
    chk("sbu_lat", lat, 32'd2);
    chk("sbu_err", {31'h0, e}, 32'h1);
    chk("sbu_rdata", rd, 32'h0);
    chk("sbu_nacc", acc_total - a0, 32'd0);
    access(1'b0, 3'b011, 32'h14, 32'h0, lat, rd, e, a0);
    chk("ld011_lat", lat, 32'd2);
    chk("ld011_err", {31'h0, e}, 32'h1);
    chk("ld011_rdata", rd, 32'h0);
    chk("ld011_nacc", acc_total - a0, 32'd0);
    access(1'b0, 3'b111, 32'h14, 32'h0, lat, rd, e, a0);
    chk("ld111_err", {31'h0, e}, 32'h1);

    // Reset during ACC0 of a misaligned store, req held high
    @(negedge clk);
    a0        = acc_total;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.size  = 3'b010;
    bus.addr  = 32'h1E;
    bus.wdata = 32'h5566_7788;
    @(posedge clk); #1;
    chk("rmid_acc0_en", {31'h0, bus.mem_en}, 32'h1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rmid_busy", {31'h0, bus.busy}, 32'h0);
    chk("rmid_en", {31'h0, bus.mem_en}, 32'h0);
    @(negedge clk); rst = 1'b1; bus.req = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("rmid_nacc", acc_total - a0, 32'd1);
    chk("rmid_w7_hi", {16'h0, ram[7][31:16]}, 32'h7788);
    chk("rmid_w8", ram[8], 32'hBEEF_5678);

    // req held high: only sampled again once back in IDLE
    @(negedge clk);
    a0        = acc_total;
    dn        = 0;
    bus.req   = 1'b1;
    bus.we    = 1'b0;
    bus.size  = 3'b010;
    bus.addr  = 32'h14;
    @(posedge clk); #1;
    chk("held_busy", {31'h0, bus.busy}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dn++;
      if (i == 3) bus.req = 1'b0;
    end
    chk("held_ndone", dn, 32'd2);
    chk("held_nacc", acc_total - a0, 32'd2);
    chk("held_rdata_last", bus.busy === 1'b0 ? 32'h0 : 32'hFFFF_FFFF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
